// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared opcodes, flag indices and response-entry type for the
//                bfloat16 FPU stream front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [3:0]  OP_ADD    = 4'b0001;
    localparam logic [3:0]  OP_SUB    = 4'b0010;
    localparam logic [3:0]  OP_MUL    = 4'b0100;
    localparam logic [3:0]  OP_DIV    = 4'b1000;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    localparam int FLG_DZ  = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_ILL = 2;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } rsp_entry_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_rsp_fifo
//  Description : Synchronous FIFO holding FPU responses; push and pop may
//                coincide at any fill level, head is valid while count != 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_rsp_fifo
    import fpu_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fpu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_stream_ctrl
//  Description : Valid/ready front end for the combinational bfloat16 FPU:
//                execute register, response FIFO and saturating statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_stream_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [15:0]      req_a_i,
    input  logic [15:0]      req_b_i,
    input  logic [3:0]       req_tag_i,
    output logic [3:0]       fpu_op_o,
    output logic [15:0]      fpu_in1_o,
    output logic [15:0]      fpu_in2_o,
    input  logic [15:0]      fpu_out_i,
    input  logic             fpu_div_zero_i,
    input  logic             fpu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_data_o,
    output logic [3:0]       rsp_tag_o,
    output logic [2:0]       rsp_flags_o,
    input  logic             stat_clr_i,
    output logic [CNT_W-1:0] stat_ops_o,
    output logic [CNT_W-1:0] stat_err_o,
    output logic             busy_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW+1:0]   C_DEPTH = (AW+2)'(DEPTH);

    logic             e_valid_q;
    logic [3:0]       e_op_q;
    logic [15:0]      e_a_q;
    logic [15:0]      e_b_q;
    logic [3:0]       e_tag_q;

    logic [CNT_W-1:0] stat_ops_q, stat_ops_d;
    logic [CNT_W-1:0] stat_err_q, stat_err_d;

    logic             w_req_fire;
    logic             w_legal;
    logic             w_pop;
    logic [AW:0]      w_count;
    logic [AW+1:0]    w_occ;
    rsp_entry_t       w_push_entry;
    rsp_entry_t       w_head;

    // Ready looks only at registered occupancy, so a push can never overflow.
    assign w_occ       = {1'b0, w_count} + {{(AW+1){1'b0}}, e_valid_q};
    assign req_ready_o = (w_occ < C_DEPTH);
    assign w_req_fire  = req_valid_i & req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
        end else begin
            e_valid_q <= w_req_fire;
        end
        if (w_req_fire) begin
            e_op_q  <= req_op_i;
            e_a_q   <= req_a_i;
            e_b_q   <= req_b_i;
            e_tag_q <= req_tag_i;
        end
    end

    assign w_legal   = op_is_legal(e_op_q);
    assign fpu_op_o  = (e_valid_q && w_legal) ? e_op_q : 4'b0000;
    assign fpu_in1_o = (e_valid_q && w_legal) ? e_a_q  : 16'h0000;
    assign fpu_in2_o = (e_valid_q && w_legal) ? e_b_q  : 16'h0000;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.tag  = e_tag_q;
        if (w_legal) begin
            w_push_entry.data           = fpu_out_i;
            w_push_entry.flags[FLG_OVF] = fpu_overflow_i;
            w_push_entry.flags[FLG_DZ]  = fpu_div_zero_i;
        end else begin
            w_push_entry.data           = BF16_QNAN;
            w_push_entry.flags[FLG_ILL] = 1'b1;
        end
    end

    fpu_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (e_valid_q),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign rsp_valid_o = (w_count != '0);
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign rsp_data_o  = rsp_valid_o ? w_head.data  : 16'h0000;
    assign rsp_tag_o   = rsp_valid_o ? w_head.tag   : 4'h0;
    assign rsp_flags_o = rsp_valid_o ? w_head.flags : 3'b000;
    assign busy_o      = e_valid_q | rsp_valid_o;

    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_err_d = stat_err_q;
        if (stat_clr_i) begin
            stat_ops_d = '0;
            stat_err_d = '0;
        end else if (e_valid_q) begin
            if (stat_ops_q != '1) begin
                stat_ops_d = stat_ops_q + CNT_W'(1);
            end
            if ((w_push_entry.flags != 3'b000) && (stat_err_q != '1)) begin
                stat_err_d = stat_err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_ops_o = stat_ops_q;
    assign stat_err_o = stat_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_stream_ctrl
//  Description : Scoreboard bench for fpu_stream_ctrl with a behavioural FPU
//                stand-in and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_stream_ctrl;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int TMO   = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [15:0]      req_a = '0;
    logic [15:0]      req_b = '0;
    logic [3:0]       req_tag = '0;
    logic [3:0]       fpu_op;
    logic [15:0]      fpu_in1, fpu_in2, fpu_out;
    logic             fpu_dz, fpu_ovf;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [15:0]      rsp_data;
    logic [3:0]       rsp_tag;
    logic [2:0]       rsp_flags;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] stat_ops, stat_err;
    logic             busy;

    int               checks = 0;
    int               errors = 0;
    rsp_entry_t       exp_q[$];
    logic [CNT_W-1:0] exp_ops = '0;
    logic [CNT_W-1:0] exp_err = '0;
    logic             rnd_done;

    always #5 clk = ~clk;

    fpu_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
        .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
        .fpu_out_i(fpu_out), .fpu_div_zero_i(fpu_dz), .fpu_overflow_i(fpu_ovf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag), .rsp_flags_o(rsp_flags),
        .stat_clr_i(stat_clr), .stat_ops_o(stat_ops), .stat_err_o(stat_err),
        .busy_o(busy)
    );

    // Stand-in FPU: exact on the directed cases, an arbitrary but deterministic
    // function of the operands elsewhere; returns {overflow, div_zero, result}.
    function automatic logic [17:0] fpu_model(input logic [3:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        dz, ovf;
        dz  = 1'b0;
        ovf = (a[14:13] == 2'b11) && (b[14:13] == 2'b11);
        case (op)
            OP_ADD:  r = (a == 16'h3F80 && b == 16'h3F80) ? 16'h4000 : a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = (a == 16'h3F80) ? b : (a ^ b);
            OP_DIV:  begin
                dz = (b[14:0] == 15'h0);
                r  = dz ? 16'h7F80 : (a ^ {b[7:0], b[15:8]});
            end
            default: begin r = 16'h0; ovf = 1'b0; end
        endcase
        return {ovf, dz, r};
    endfunction

    assign {fpu_ovf, fpu_dz, fpu_out} = fpu_model(fpu_op, fpu_in1, fpu_in2);

    function automatic rsp_entry_t ref_rsp(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] tag);
        rsp_entry_t  e;
        logic [17:0] f;
        e.tag = tag;
        if ($countones(op) == 1) begin
            f       = fpu_model(op, a, b);
            e.data  = f[15:0];
            e.flags = {1'b0, f[17], f[16]};
        end else begin
            e.data  = 16'h7FC0;
            e.flags = 3'b100;
        end
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-side scoreboard feed: an accepted request enqueues its expected response.
    always @(negedge clk) begin
        rsp_entry_t e;
        if (!rst && req_valid && req_ready) begin
            e = ref_rsp(req_op, req_a, req_b, req_tag);
            exp_q.push_back(e);
            exp_ops = sat_inc(exp_ops);
            if (e.flags != 3'b000) exp_err = sat_inc(exp_err);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_entry_t e;
        if (!rst) begin
            chk("fpu_op_onehot_or_zero", ($countones(fpu_op) <= 1), 1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data",  rsp_data,  e.data);
                    chk("rsp_tag",   rsp_tag,   e.tag);
                    chk("rsp_flags", rsp_flags, e.flags);
                end
            end else if (!rsp_valid) begin
                chk("rsp_idle_zero", {rsp_data, rsp_tag, rsp_flags}, 0);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
            waited++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string name);
        drain();
        chk({name, "_ops"}, stat_ops, exp_ops);
        chk({name, "_err"}, stat_err, exp_err);
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        exp_ops = '0;
        exp_err = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stats", {stat_ops, stat_err}, 0);
        chk("reset_fpu_drive", {fpu_op, fpu_in1, fpu_in2} != 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Multiply with two-edge latency.
        rsp_ready = 1'b1;
        send(OP_MUL, 16'h3F80, 16'h4000, 4'd5, w);
        chk("mul_not_early", rsp_valid, 0);
        @(posedge clk); #1;
        chk("mul_valid_at_2", rsp_valid, 1);
        chk("mul_data", rsp_data, 16'h4000);
        chk("mul_tag_flags", {rsp_tag, rsp_flags}, {4'd5, 3'b000});
        check_stats("mul");

        // Divide by zero, then counter clear.
        send(OP_DIV, 16'h3F80, 16'h0000, 4'd1, w);
        check_stats("divz");
        chk("divz_err_is_1", stat_err, 1);
        clear_stats();
        chk("clr_zero", {stat_ops, stat_err}, 0);

        // Illegal opcode never reaches the FPU.
        send(4'b0011, 16'h4040, 16'h4000, 4'd7, w);
        chk("ill_fpu_op_zero", fpu_op, 4'b0000);
        chk("ill_fpu_in_zero", {fpu_in1, fpu_in2}, 0);
        check_stats("ill");

        // Backpressure: four fit, the fifth stalls until the consumer returns.
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(OP_ADD, 16'h1000 + 16'(t), 16'h0100, 4'(t), w);
        req_op = OP_ADD; req_a = 16'h1004; req_b = 16'h0100; req_tag = 4'd4; req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 0);
        end
        @(posedge clk); #1;
        fork
            begin
                send(OP_ADD, 16'h1004, 16'h0100, 4'd4, w);
                send(OP_ADD, 16'h1005, 16'h0100, 4'd5, w);
            end
            begin
                rsp_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_consecutive", {rsp_valid, rsp_tag}, {1'b1, 4'(i)});
                end
            end
        join
        check_stats("bp");

        // Streaming at full rate, then saturation.
        clear_stats();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(OP_ADD, 16'h3F80, 16'h3F80, 4'(i), w);
                    chk("stream_no_stall", w, 0);
                end
            end
            begin
                for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
                for (int k = 0; k < 10; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("stream_valid", rsp_valid, 1);
                end
            end
        join
        check_stats("stream10");
        for (int i = 0; i < 7; i++) send(OP_ADD, 16'h3F80, 16'h3F80, 4'(i), w);
        check_stats("sat17");
        chk("sat_ops_15", stat_ops, 4'hF);

        // Randomised traffic with random consumer stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    logic [3:0] op;
                    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'(1 << $urandom_range(0, 3));
                    send(op, 16'($urandom),
                         ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                         4'($urandom), w);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        check_stats("random");

        // Reset while E is valid and the FIFO holds two entries.
        rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) send(OP_SUB, 16'h2000, 16'(t), 4'(t), w);
        chk("pre_rst_busy", {busy, rsp_valid}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stats", {stat_ops, stat_err}, 0);
        chk("rst_req_ready", req_ready, 1);
        exp_q.delete();
        exp_ops = '0;
        exp_err = '0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        send(OP_MUL, 16'h3F80, 16'h4040, 4'd9, w);
        check_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
